// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 transmitter.
// Performs the request-to-send handshake, then shifts out start, 8 data
// bits (LSB first), odd parity and stop on the device-generated clock.
// After that it samples the device ACK. Both pads are open-drain and are
// driven through the *_low outputs. A watchdog aborts the transfer if the
// device stops clocking.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 13000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       ps2c_low,
  output logic       ps2d_low,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RTS       = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] ACK       = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  // Input conditioning. Index 0 is the clock line and index 1 is the data line.
  logic [1:0]         c_sync, d_sync;
  logic [1:0]         raw_s;
  logic [1:0]         filt;
  logic [1:0][FW-1:0] fcnt;
  logic               fall;

  // Transfer state
  logic [2:0]    state;
  logic [8:0]    shreg;
  logic [3:0]    cnt;
  logic [IW-1:0] inh;
  logic [WW-1:0] wd;

  assign raw_s = {d_sync[1], c_sync[1]};

  // Two-stage synchronizers. The idle bus level is 1, so the registers reset to 1.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments. This way every
    // flop samples values from before the edge, whatever order the
    // statements are written in.
    if (!reset) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
    end
  end

  // Glitch filter. The filtered level follows the synchronized level only
  // after FILTER_LEN consecutive samples that disagree with it. The same
  // block registers the falling-edge pulse of the filtered clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt <= 2'b11;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      fall <= filt[0] & ~raw_s[0] & (fcnt[0] == FLT_LAST);
      for (int i = 0; i < 2; i++) begin
        if (raw_s[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FLT_LAST) begin
          filt[i] <= raw_s[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  // Transfer FSM. It also drives the registered pad controls and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      inh          <= '0;
      wd           <= '0;
      ps2c_low     <= 1'b0;
      ps2d_low     <= 1'b0;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
      tx_err       <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_ps2) begin
            shreg    <= {~^din, din};
            tx_err   <= 1'b0;
            tx_idle  <= 1'b0;
            ps2c_low <= 1'b1;
            inh      <= '0;
            cnt      <= '0;
            state    <= RTS;
          end
        end
        RTS: begin
          // Hold the clock low, then assert the start bit as the clock is released.
          if (inh == INH_LAST) begin
            ps2c_low <= 1'b0;
            ps2d_low <= 1'b1;
            wd       <= '0;
            state    <= START;
          end else begin
            inh <= inh + 1'b1;
          end
        end
        START, DATA, ACK: begin
          if (fall) begin
            // A device clock edge always wins over an expiring watchdog.
            wd  <= '0;
            cnt <= cnt + 1'b1;
            if (state == START) begin
              ps2d_low <= ~shreg[0];
              shreg    <= {1'b0, shreg[8:1]};
              state    <= DATA;
            end else if (state == DATA) begin
              if (cnt == 4'd9) begin
                ps2d_low <= 1'b0;
                state    <= ACK;
              end else begin
                ps2d_low <= ~shreg[0];
                shreg    <= {1'b0, shreg[8:1]};
              end
            end else begin
              if (filt[1]) tx_err <= 1'b1;
              state <= WAIT_IDLE;
            end
          end else if (wd == WD_LAST) begin
            ps2c_low     <= 1'b0;
            ps2d_low     <= 1'b0;
            tx_err       <= 1'b1;
            tx_done_tick <= 1'b1;
            tx_idle      <= 1'b1;
            wd           <= '0;
            state        <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (filt[0] && filt[1]) begin
            tx_done_tick <= 1'b1;
            tx_idle      <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Directed testbench for ps2_tx. It models the open-drain bus and a PS/2
// device that clocks frames, samples each bit on the rising clock and
// optionally ACKs.
module tb_ps2_tx;

  localparam int INH = 40;
  localparam int FLT = 4;
  localparam int TMO = 600;
  localparam int H   = 30;  // device half clock period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = '0;
  logic       ps2c, ps2d;
  logic       ps2c_low, ps2d_low, tx_idle, tx_done_tick, tx_err;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int clow_cnt = 0;
  int dev_falls = 0;

  assign ps2c = ~(ps2c_low | dev_c_low);
  assign ps2d = ~(ps2d_low | dev_d_low);

  ps2_tx #(.INHIBIT_CYCLES(INH), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din),
    .ps2c(ps2c), .ps2d(ps2d),
    .ps2c_low(ps2c_low), .ps2d_low(ps2d_low), .tx_idle(tx_idle),
    .tx_done_tick(tx_done_tick), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done_tick) done_cnt++;
    if (ps2c_low) clow_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    din = b;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  // Device model. frame[0] is the start bit. frame[k] is sampled at the rise after fall k.
  task automatic dev_xfer(input bit ack, input int stop_at,
                          output logic [10:0] frame, output int lat1);
    int n;
    logic prev;
    frame = '0;
    lat1 = 0;
    dev_falls = 0;
    n = 0;
    while (!ps2c_low && n < 2000) begin @(negedge clk); n++; end
    check("rts_seen", 32'(ps2c_low), 32'd1);
    n = 0;
    while (!(ps2d_low && !ps2c_low) && n < 2000) begin @(negedge clk); n++; end
    check("start_seen", 32'({ps2c_low, ps2d_low}), 32'b01);
    repeat (H) @(negedge clk);
    frame[0] = ps2d;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        dev_d_low = ack;
        repeat (H / 2) @(negedge clk);
      end
      prev = ps2d_low;
      dev_c_low = 1'b1;
      dev_falls = k;
      if (k == stop_at) return;
      for (int i = 1; i <= H; i++) begin
        @(negedge clk);
        if (k == 1 && lat1 == 0 && ps2d_low != prev) lat1 = i;
      end
      dev_c_low = 1'b0;
      if (k <= 10) frame[k] = ps2d;
      repeat ((k == 10) ? H / 2 : H) @(negedge clk);
    end
    dev_d_low = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!tx_idle && n < 500) begin @(negedge clk); n++; end
    check(tag, 32'(tx_idle), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [10:0] f,
                             input logic [7:0] data, input logic par);
    check({tag, "_start"}, 32'(f[0]), 32'd0);
    check({tag, "_data"}, 32'(f[8:1]), 32'(data));
    check({tag, "_par"}, 32'(f[9]), 32'(par));
    check({tag, "_stop"}, 32'(f[10]), 32'd1);
  endtask

  initial begin
    logic [10:0] frame;
    int lat, d0, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_c_low", 32'(ps2c_low), 32'd0);
    check("rst_d_low", 32'(ps2d_low), 32'd0);
    check("rst_idle", 32'(tx_idle), 32'd1);
    check("rst_done", 32'(tx_done_tick), 32'd0);
    check("rst_err", 32'(tx_err), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED with ACK: 6 ones -> odd parity bit 1
    d0 = done_cnt;
    clow_cnt = 0;
    send(8'hED);
    check("ed_busy", 32'(tx_idle), 32'd0);
    dev_xfer(1'b1, 0, frame, lat);
    wait_idle("ed_idle");
    check_frame("ed", frame, 8'hED, 1'b1);
    check("ed_inhibit", 32'(clow_cnt), 32'(INH));
    check("ed_latency", 32'(lat), 32'(2 + FLT + 1));
    check("ed_done", 32'(done_cnt - d0), 32'd1);
    check("ed_err", 32'(tx_err), 32'd0);

    // 0x00 -> parity 1, 0x01 -> parity 0
    send(8'h00);
    dev_xfer(1'b1, 0, frame, lat);
    wait_idle("x00_idle");
    check_frame("x00", frame, 8'h00, 1'b1);
    check("x00_err", 32'(tx_err), 32'd0);
    send(8'h01);
    dev_xfer(1'b1, 0, frame, lat);
    wait_idle("x01_idle");
    check_frame("x01", frame, 8'h01, 1'b0);
    check("x01_err", 32'(tx_err), 32'd0);

    // Missing ACK
    d0 = done_cnt;
    send(8'hFF);
    dev_xfer(1'b0, 0, frame, lat);
    wait_idle("nak_idle");
    check("nak_err", 32'(tx_err), 32'd1);
    check("nak_done", 32'(done_cnt - d0), 32'd1);

    // Device never clocks: abort TMO cycles after entering START
    d0 = done_cnt;
    send(8'h55);
    check("tmo_err_clr", 32'(tx_err), 32'd0);
    n = 0;
    while (!(ps2d_low && !ps2c_low) && n < 2000) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_done_tick && n < TMO + 100);
    check("tmo_cycles", 32'(n), 32'(TMO));
    check("tmo_pads", 32'({ps2c_low, ps2d_low}), 32'd0);
    check("tmo_err", 32'(tx_err), 32'd1);
    check("tmo_idle", 32'(tx_idle), 32'd1);
    @(negedge clk);
    check("tmo_done", 32'(done_cnt - d0), 32'd1);

    // wr_ps2 while busy is ignored: 0xF4 has 5 ones -> parity 0
    d0 = done_cnt;
    send(8'hF4);
    fork
      dev_xfer(1'b1, 0, frame, lat);
      begin
        int m = 0;
        while (dev_falls < 3 && m < 5000) begin @(negedge clk); m++; end
        din = 8'hAA;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
      end
    join
    wait_idle("busy_idle");
    check_frame("busy", frame, 8'hF4, 1'b0);
    check("busy_err", 32'(tx_err), 32'd0);
    repeat (INH + 10) @(negedge clk);
    check("busy_no_restart", 32'(ps2c_low), 32'd0);
    check("busy_done", 32'(done_cnt - d0), 32'd1);

    // Reset at fall #5 during a 0x00 transfer (bit3 = 0 keeps data low)
    d0 = done_cnt;
    send(8'h00);
    dev_xfer(1'b1, 5, frame, lat);
    check("rmid_pre_d", 32'(ps2d_low), 32'd1);
    reset = 1'b0;
    #1;
    check("rmid_pads", 32'({ps2c_low, ps2d_low}), 32'd0);
    check("rmid_idle", 32'(tx_idle), 32'd1);
    repeat (3) @(negedge clk);
    dev_c_low = 1'b0;
    reset = 1'b1;
    repeat (50) @(negedge clk);
    check("rmid_no_done", 32'(done_cnt - d0), 32'd0);

    // 0xFF afterwards completes: 8 ones -> parity 1
    d0 = done_cnt;
    send(8'hFF);
    dev_xfer(1'b1, 0, frame, lat);
    wait_idle("ff_idle");
    check_frame("ff", frame, 8'hFF, 1'b1);
    check("ff_err", 32'(tx_err), 32'd0);
    check("ff_done", 32'(done_cnt - d0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
Host-to-device PS/2 transmitter; the send side of the PS/2 link, paired with the existing ps2_rx receiver. It sends command bytes to the Nexys4 USB-to-PS/2 keyboard port, e.g. 0xED plus an LED mask, or 0xFF reset. It owns the open-drain clock and data pins during a transfer. While busy it deasserts tx_idle, which gates ps2_rx's rx_en so the receiver ignores host-driven frames.

Parameters:
INHIBIT_CYCLES, 13000, clk cycles ps2c is held low for request-to-send (130 us at 100 MHz; must be >= 100 us)
FILTER_LEN, 8, consecutive equal synchronized samples required to change the filtered ps2c/ps2d level
TIMEOUT_CYCLES, 2000000, max clk cycles between device clock falling edges before abort (20 ms at 100 MHz)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset)
wr_ps2  input  1  one-cycle start request; sampled only in IDLE
din  input  8  byte to send; latched on accepted wr_ps2
ps2c  input  1  PS/2 clock pin level (read back from the pad)
ps2d  input  1  PS/2 data pin level (read back from the pad)
ps2c_low  output  1  1 = pull clock pad low; top level drives the pad with ps2c_low ? 0 : 'z
ps2d_low  output  1  1 = pull data pad low; top level drives the pad with ps2d_low ? 0 : 'z
tx_idle  output  1  1 = no transfer in progress; drives ps2_rx rx_en
tx_done_tick  output  1  one-cycle pulse at the end of every transfer, success or abort
tx_err  output  1  status of the last transfer: 1 = no ACK or timeout; cleared by the next accepted wr_ps2

Behaviour:
- Reset (reset=0, async): state IDLE, ps2c_low=0, ps2d_low=0, tx_idle=1, tx_done_tick=0, tx_err=0, filtered ps2c/ps2d=1, all counters 0.
- Input conditioning: ps2c and ps2d each pass a 2-FF synchronizer, then a FILTER_LEN-sample glitch filter.
- fall = one-cycle pulse when filtered ps2c goes 1->0.
- All outputs are registered.
- IDLE: tx_idle=1, both pads released. On wr_ps2=1:
  - latch din into the shift register;
  - compute parity = ~^din (odd parity);
  - clear tx_err, go to RTS; tx_idle=0 from the next cycle.
- RTS: ps2c_low=1 for exactly INHIBIT_CYCLES cycles. On the last count, go to START: ps2d_low=1 (start bit) and ps2c_low=0, both in the same registered update.
- START: hold ps2d_low=1. On fall #1, drive bit0 and go to DATA.
- DATA: data bits go out LSB first and change only after a fall. Any bit value 1 is sent as a released pad, ps2d_low=0.
  - falls #2..#8: bits 1..7;
  - fall #9: parity bit;
  - fall #10: release data (stop bit, ps2d_low=0) and go to ACK.
- ACK: on fall #11, sample filtered ps2d. 0 = ACK, go to WAIT_IDLE with tx_err unchanged at 0. 1 = no ACK, set tx_err=1, go to WAIT_IDLE.
- WAIT_IDLE: wait until filtered ps2c=1 and filtered ps2d=1, then pulse tx_done_tick for one cycle and return to IDLE.
- Timeout: in START, DATA or ACK, a watchdog counts cycles and resets on every fall. On reaching TIMEOUT_CYCLES:
  - release both pads, set tx_err=1, pulse tx_done_tick;
  - go directly to IDLE without waiting for the bus to idle.
- Busy behaviour: wr_ps2 during any non-IDLE state is ignored and din is not re-latched.
- Simultaneous events: if fall and timeout occur in the same cycle, fall wins and the watchdog clears.
- Response latency: ps2d_low changes exactly 1 clk after the fall pulse. That is 2 + FILTER_LEN + 1 clk after the raw pad edge.
- Reset mid-transfer: both pads are released immediately (asynchronously) and no tx_done_tick is issued.
- Bit and edge counter: 4 bits, range 0..11, cleared on entry to RTS.

Test Plan:
- Send 0xED with a bench device model that clocks at 12.5 kHz and ACKs -> ps2c_low high for 13000 clk; ps2d sequence after start = 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done_tick once; tx_err=0; tx_idle back to 1.
- Send 0x00, then 0x01 -> parity bits 1 and 0 respectively; model receives 0x00 and 0x01 intact.
- Device model omits ACK (ps2d stays 1 at fall #11) -> tx_err=1, one tx_done_tick after the bus idles.
- Device never clocks after RTS -> abort exactly TIMEOUT_CYCLES after entering START; pads released; tx_err=1; tx_done_tick pulse.
- wr_ps2 with din=0xAA pulsed during DATA of a 0xF4 transfer -> ignored; model receives 0xF4 only.
- reset=0 asserted at fall #5 -> ps2c_low=ps2d_low=0 immediately, tx_idle=1, no tx_done_tick; a following 0xFF transfer completes with tx_err=0.
